// File: rtl/spi_responder_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_responder_regfile: SPI mode-0 slave backed by a 2**ADDR_W x 8 regfile |
// | Optional SPI_BURST_EN: address auto-increment on BURST header. Rev 1.0    |
// +--------------------------------------------------------------------------+
module spi_responder_regfile #(
  parameter int ADDR_W      = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK_48MHZ,
  input  logic              RESET,
  input  logic              SS,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_OE,
  input  logic [7:0]        status_in,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              xfer_done
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
  logic ss_s, ss_p, ss_f, sclk_s, sclk_p, mosi_s;
  logic ss_stable, ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic byte_done, reg_we;
  logic [2:0] cnt;
  logic [6:0] rx;
  logic [7:0] rx_byte, tx;
  logic rw;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [7:0] regs [DEPTH];
`ifdef SPI_BURST_EN
  logic burst;
`endif

  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      ss_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_p      <= 1'b1;
      ss_f      <= 1'b1;
      sclk_p    <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      ss_p      <= ss_s;
      sclk_p    <= sclk_s;
      if (ss_stable) ss_f <= ss_s;
    end
  end

  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // SS must hold a level for two synchronized cycles before it counts
  assign ss_stable = (ss_s == ss_p);
  assign ss_fall   = ss_stable && !ss_s && ss_f;
  assign ss_rise   = ss_stable && ss_s && !ss_f;
  assign sclk_rise = sclk_s && !sclk_p;
  assign sclk_fall = !sclk_s && sclk_p;

  assign rx_byte   = {rx, mosi_s};
  assign byte_done = sclk_rise && (cnt == 3'd7);
  assign reg_we    = (state == DATA) && !ss_rise && byte_done && !rw;

  always_comb begin
    addr_nxt = addr;
`ifdef SPI_BURST_EN
    if (burst) addr_nxt = addr + {{(ADDR_W-1){1'b0}}, 1'b1};
`endif
  end

  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall) state_nxt = HEADER;
      HEADER:  if (ss_rise) state_nxt = IDLE;
               else if (byte_done) state_nxt = DATA;
      DATA:    if (ss_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[addr] <= rx_byte;
    end
  end

  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      cnt       <= '0;
      rx        <= '0;
      tx        <= '0;
      rw        <= 1'b0;
      addr      <= '0;
      MISO      <= 1'b0;
      MISO_OE   <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      xfer_done <= 1'b0;
`ifdef SPI_BURST_EN
      burst     <= 1'b0;
`endif
    end else begin
      wr_stb    <= 1'b0;
      xfer_done <= 1'b0;
      if (ss_rise) begin
        cnt       <= '0;
        MISO      <= 1'b0;
        MISO_OE   <= 1'b0;
        xfer_done <= 1'b1;
      end else if (state == IDLE) begin
        if (ss_fall) begin
          tx      <= status_in;
          MISO    <= status_in[7];
          MISO_OE <= 1'b1;
          cnt     <= '0;
        end
      end else if (sclk_rise) begin
        rx  <= rx_byte[6:0];
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          if (state == HEADER) begin
            rw   <= rx_byte[7];
            addr <= rx_byte[ADDR_W-1:0];
`ifdef SPI_BURST_EN
            burst <= rx_byte[6];
`endif
            if (rx_byte[7]) tx <= regs[rx_byte[ADDR_W-1:0]];
          end else if (!rw) begin
            wr_stb  <= 1'b1;
            wr_addr <= addr;
            wr_data <= rx_byte;
            addr    <= addr_nxt;
          end else begin
            tx   <= regs[addr_nxt];
            addr <= addr_nxt;
          end
        end
      end else if (sclk_fall) begin
        // cnt==0 here means a fresh byte was just loaded into tx
        MISO <= tx[3'd7 - cnt];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_responder_regfile.sv
`default_nettype none
// Scoreboard bench for spi_responder_regfile: directed SPI transactions against a small regfile model.
module tb_spi_responder_regfile;
  logic       clk = 1'b0;
  logic       rst, ss, sclk, mosi;
  logic       miso, miso_oe, wr_stb, xfer_done;
  logic [7:0] status_in, wr_data;
  logic [5:0] wr_addr;

  always #5 clk = ~clk;

  spi_responder_regfile #(.ADDR_W(6), .SYNC_STAGES(2)) dut (
    .CLK_48MHZ (clk),
    .RESET     (rst),
    .SS        (ss),
    .SCLK      (sclk),
    .MOSI      (mosi),
    .MISO      (miso),
    .MISO_OE   (miso_oe),
    .status_in (status_in),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .xfer_done (xfer_done)
  );

  typedef struct {
    bit         care;
    logic [7:0] val;
  } rd_exp_t;

  int         checks = 0;
  int         errors = 0;
  rd_exp_t    exp_miso[$];
  logic [13:0] exp_wr[$];
  bit         exp_done_q[$];
  logic [7:0] model [64];
  logic [7:0] miso_sh = 8'h00;
  int         miso_bits = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // MISO bytes as the master sees them on SCLK rising edges
  always @(posedge sclk) begin
    if (ss === 1'b0) begin
      chk("miso_oe_active", {31'd0, miso_oe}, 32'd1);
      miso_sh = {miso_sh[6:0], miso};
      miso_bits++;
      if (miso_bits == 8) begin
        rd_exp_t e;
        miso_bits = 0;
        if (exp_miso.size() == 0) begin
          checks++; errors++;
          $display("FAIL miso_unexpected_byte: got %h want none", miso_sh);
        end else begin
          e = exp_miso.pop_front();
          if (e.care) chk("miso_byte", {24'd0, miso_sh}, {24'd0, e.val});
        end
      end
    end
  end

  always @(posedge ss) miso_bits = 0;

  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_stb_spurious: got addr %h data %h want none", wr_addr, wr_data);
      end else begin
        chk("wr_addr_data", {18'd0, wr_addr, wr_data}, {18'd0, exp_wr.pop_front()});
      end
    end
    if (xfer_done === 1'b1) begin
      if (exp_done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL xfer_done_spurious: got 1 want 0");
      end else begin
        void'(exp_done_q.pop_front());
        checks++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // SCLK = clk/8; MOSI changes 0..jit clocks after SCLK falls
  task automatic send_bits(input logic [7:0] b, input int nbits, input int jit);
    int j;
    for (int i = 0; i < nbits; i++) begin
      j = (jit > 0) ? int'($urandom_range(0, jit)) : 0;
      tick(j);
      mosi = b[7-i];
      tick(4 - j);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] hdr, input int n, input logic [63:0] d,
                      input int jit, input int abort_bits);
    logic [5:0] a;
    logic [7:0] db;
    a = hdr[5:0];
    exp_miso.push_back('{1'b1, status_in});
    for (int i = 0; i < n; i++) begin
      db = d[63-8*i -: 8];
      if (hdr[7]) begin
        exp_miso.push_back('{1'b1, model[a]});
      end else begin
        exp_miso.push_back('{1'b0, 8'h00});
        model[a] = db;
        exp_wr.push_back({a, db});
      end
`ifdef SPI_BURST_EN
      if (hdr[6]) a = a + 6'd1;
`endif
    end
    exp_done_q.push_back(1'b1);
    ss = 1'b0;
    tick(8);
    send_bits(hdr, 8, jit);
    for (int i = 0; i < n; i++) send_bits(hdr[7] ? 8'h00 : d[63-8*i -: 8], 8, jit);
    if (abort_bits > 0) send_bits(8'hC7, abort_bits, jit);
    tick(4);
    ss = 1'b1;
    tick(12);
    chk("miso_oe_idle", {31'd0, miso_oe}, 32'd0);
    chk("miso_idle", {31'd0, miso}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0; status_in = 8'h00;
    for (int i = 0; i < 64; i++) model[i] = 8'h00;
    tick(5);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    chk("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
    chk("rst_wr_addr", {26'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_xfer_done", {31'd0, xfer_done}, 32'd0);
    rst = 1'b0;
    tick(5);

    status_in = 8'h3C;
    xfer(8'h05, 1, {8'hA5, 56'd0}, 0, 0);
    chk("last_wr_addr", {26'd0, wr_addr}, 32'd5);
    chk("last_wr_data", {24'd0, wr_data}, 32'hA5);

    status_in = 8'hC3;
    xfer(8'h85, 1, 64'd0, 0, 0);

    status_in = 8'h96;
    xfer(8'h7F, 2, {8'h11, 8'h22, 48'd0}, 0, 0);
    xfer(8'hFF, 2, 64'd0, 0, 0);
    xfer(8'h80, 1, 64'd0, 0, 0);
    xfer(8'hBF, 1, 64'd0, 0, 0);

    // partial data byte must not write
    xfer(8'h0A, 1, {8'h5C, 56'd0}, 0, 0);
    xfer(8'h0A, 0, 64'd0, 0, 5);
    xfer(8'h8A, 1, 64'd0, 0, 0);
    chk("wr_data_after_abort", {24'd0, wr_data}, 32'h5C);

    status_in = 8'h01;
    xfer(8'h50, 8, 64'h0123456789ABCDEF, 3, 0);
    xfer(8'hD0, 8, 64'd0, 3, 0);

    // one-cycle SS glitch is ignored
    ss = 1'b0;
    tick(1);
    ss = 1'b1;
    tick(12);
    chk("glitch_miso_oe", {31'd0, miso_oe}, 32'd0);

    // reset in the middle of a data byte
    status_in = 8'hE7;
    exp_miso.push_back('{1'b1, 8'hE7});
    ss = 1'b0;
    tick(8);
    send_bits(8'h03, 8, 0);
    send_bits(8'hEE, 4, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_miso", {31'd0, miso}, 32'd0);
    chk("midrst_miso_oe", {31'd0, miso_oe}, 32'd0);
    chk("midrst_wr_stb", {31'd0, wr_stb}, 32'd0);
    chk("midrst_wr_addr", {26'd0, wr_addr}, 32'd0);
    chk("midrst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("midrst_xfer_done", {31'd0, xfer_done}, 32'd0);
    tick(1);
    ss = 1'b1;
    tick(5);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) model[i] = 8'h00;
    tick(5);
    xfer(8'h83, 1, 64'd0, 0, 0);
    xfer(8'h85, 1, 64'd0, 0, 0);
    xfer(8'hBF, 1, 64'd0, 0, 0);

    tick(20);
    chk("pending_miso", exp_miso.size(), 32'd0);
    chk("pending_wr", exp_wr.size(), 32'd0);
    chk("pending_done", exp_done_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
